edge_trig_ctrl: RTL and testbench

Controller that sequences the mov_sum HLS moving-sum core for the edge trigger.
- Latches configuration and issues ap_start.
- Feeds ADC samples through a small buffer with offset-to-signed conversion.
- Masks window warm-up and compares each sum against a signed threshold.
- Emits a trigger pulse, honouring one-shot/holdoff policy.
Sits between the ADC capture path and the scope trigger mux.

---
 rtl/edge_trig_ctrl_pkg.sv | 24 ++
 rtl/edge_trig_ctrl_if.sv | 31 +++
 rtl/edge_sample_fifo.sv | 61 ++++++
 rtl/edge_trig_ctrl.sv | 165 ++++++++++++++++
 tb/tb_edge_trig_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_trig_ctrl_pkg.sv
// Shared types and helpers for the edge trigger controller.
package edge_trig_pkg;

  // Controller states; every state except IDLE counts as armed.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_IDLE,
    START,
    WARMUP,
    RUN,
    HOLDOFF
  } state_t;

  // Mid-scale code of the default 10-bit offset-binary ADC.
  localparam int unsigned ADC_OFFSET = 512;

  // Offset binary to two's complement: subtracting half scale is the same as
  // flipping the MSB of a width-bit sample.
  function automatic logic [31:0] adc_to_signed(input logic [31:0] raw,
                                                input int unsigned width);
    return raw ^ (32'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/edge_trig_ctrl_if.sv
// Handshake, stream and result signals between the controller and mov_sum.
interface edge_trig_ctrl_if #(
  parameter int ADC_W = 10,
  parameter int SUM_W = 32,
  parameter int WIN_W = 8
);
  logic             ms_ap_start;
  logic             ms_ap_idle;
  logic             ms_ap_ready;
  logic [WIN_W-1:0] ms_window_width;
  logic             ms_absolute_value;
  logic [ADC_W-1:0] ms_datain_dout;
  logic             ms_datain_empty_n;
  logic             ms_datain_read;
  logic [SUM_W-1:0] ms_sumout;
  logic             ms_sumout_vld;

  // Controller side.
  modport master (
    output ms_ap_start, ms_window_width, ms_absolute_value,
           ms_datain_dout, ms_datain_empty_n,
    input  ms_ap_idle, ms_ap_ready, ms_datain_read, ms_sumout, ms_sumout_vld
  );

  // mov_sum core side.
  modport slave (
    input  ms_ap_start, ms_window_width, ms_absolute_value,
           ms_datain_dout, ms_datain_empty_n,
    output ms_ap_idle, ms_ap_ready, ms_datain_read, ms_sumout, ms_sumout_vld
  );
endinterface

// File: rtl/edge_sample_fifo.sv
// Small first-word-fall-through sample buffer with flush and drop flag.
module edge_sample_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty_n,
  output logic         o_drop
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_do_pop;
  logic          w_do_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // A pop in the same cycle frees a slot, so a push into a full buffer is kept.
  assign w_do_pop  = i_pop && !w_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);
  assign o_drop    = i_push && !i_flush && w_full && !w_do_pop;

  assign o_empty_n = !w_empty;
  // Head is presented combinationally; zero while empty so stale data never shows.
  assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; no reset needed since the data is qualified by the count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= AW'(r_wr_ptr + AW'(1));
      if (w_do_pop)  r_rd_ptr <= AW'(r_rd_ptr + AW'(1));
      if (w_do_push && !w_do_pop)      r_count <= CW'(r_count + CW'(1));
      else if (w_do_pop && !w_do_push) r_count <= CW'(r_count - CW'(1));
    end
  end
endmodule

// File: rtl/edge_trig_ctrl.sv
// Sequences the mov_sum core, feeds it samples and turns sums into triggers.
module edge_trig_ctrl
  import edge_trig_pkg::*;
#(
  parameter int ADC_W      = 10,
  parameter int SUM_W      = 32,
  parameter int WIN_W      = 8,
  parameter int HOLD_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              arm,
  input  logic [WIN_W-1:0]  cfg_window_width,
  input  logic              cfg_absolute,
  input  logic [SUM_W-1:0]  cfg_threshold,
  input  logic              cfg_falling,
  input  logic              cfg_oneshot,
  input  logic [HOLD_W-1:0] cfg_holdoff,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              adc_valid,
  edge_trig_ctrl_if.master  ms,
  output logic              trig_out,
  output logic              armed,
  output logic              overflow,
  output logic [15:0]       trig_count
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_arm_d;
  logic [WIN_W-1:0]  r_width;
  logic              r_abs;
  logic [SUM_W-1:0]  r_thr;
  logic              r_falling;
  logic              r_oneshot;
  logic [HOLD_W-1:0] r_holdoff;
  logic [WIN_W-1:0]  r_warm_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_trig;
  logic              r_overflow;
  logic [15:0]       r_trig_count;

  logic              w_arm_rise;
  logic              w_flush;
  logic              w_drop;
  logic [ADC_W-1:0]  w_push_data;
  logic              w_warm_done;
  logic              w_cmp;
  logic              w_hit;
  logic signed [SUM_W:0] w_sum_ext;
  logic signed [SUM_W:0] w_thr_ext;
  logic signed [SUM_W:0] w_neg_thr;

  assign w_arm_rise  = arm && !r_arm_d;
  assign w_push_data = ADC_W'(adc_to_signed(32'(adc_data), ADC_W));
  // Buffer is held empty in IDLE and cleared on the way there.
  assign w_flush     = (r_state == IDLE) || (w_state_next == IDLE);
  assign w_warm_done = ms.ms_sumout_vld && (r_warm_cnt == WIN_W'(r_width - WIN_W'(1)));

  // One extra bit so negating the most-negative threshold cannot wrap.
  assign w_sum_ext = {ms.ms_sumout[SUM_W-1], ms.ms_sumout};
  assign w_thr_ext = {r_thr[SUM_W-1], r_thr};
  assign w_neg_thr = -w_thr_ext;
  assign w_cmp     = r_falling ? (w_sum_ext < w_neg_thr) : (w_sum_ext > w_thr_ext);
  assign w_hit     = (r_state == RUN) && ms.ms_sumout_vld && w_cmp;

  assign ms.ms_window_width   = r_width;
  assign ms.ms_absolute_value = r_abs;
  assign trig_out             = r_trig;
  assign overflow             = r_overflow;
  assign trig_count           = r_trig_count;

  edge_sample_fifo #(
    .W     (ADC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .i_flush   (w_flush),
    .i_push    (adc_valid),
    .i_data    (w_push_data),
    .i_pop     (ms.ms_datain_read),
    .o_data    (ms.ms_datain_dout),
    .o_empty_n (ms.ms_datain_empty_n),
    .o_drop    (w_drop)
  );

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= IDLE;
    else           r_state <= w_state_next;
  end

  // Next-state logic; dropping arm wins over everything else.
  always_comb begin
    w_state_next = r_state;
    if (!arm) begin
      w_state_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:      if (w_arm_rise) w_state_next = WAIT_IDLE;
        WAIT_IDLE: if (ms.ms_ap_idle) w_state_next = START;
        START:     if (ms.ms_ap_ready) w_state_next = WARMUP;
        WARMUP:    if (w_warm_done) w_state_next = RUN;
        RUN: begin
          if (w_hit) begin
            if (r_oneshot)           w_state_next = IDLE;
            else if (r_holdoff != '0) w_state_next = HOLDOFF;
          end
        end
        HOLDOFF:   if (ms.ms_sumout_vld && r_hold_cnt == HOLD_W'(1)) w_state_next = RUN;
        default:   w_state_next = IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    ms.ms_ap_start = (r_state == START);
    armed          = (r_state != IDLE);
  end

  // Configuration latch, warm-up/holdoff counters, trigger pulse and status.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_arm_d      <= 1'b0;
      r_width      <= WIN_W'(1);
      r_abs        <= 1'b0;
      r_thr        <= '0;
      r_falling    <= 1'b0;
      r_oneshot    <= 1'b0;
      r_holdoff    <= '0;
      r_warm_cnt   <= '0;
      r_hold_cnt   <= '0;
      r_trig       <= 1'b0;
      r_overflow   <= 1'b0;
      r_trig_count <= '0;
    end else begin
      r_arm_d <= arm;
      r_trig  <= w_hit;
      if (w_arm_rise && r_state == IDLE) begin
        r_width      <= (cfg_window_width == '0) ? WIN_W'(1) : cfg_window_width;
        r_abs        <= cfg_absolute;
        r_thr        <= cfg_threshold;
        r_falling    <= cfg_falling;
        r_oneshot    <= cfg_oneshot;
        r_holdoff    <= cfg_holdoff;
        r_warm_cnt   <= '0;
        r_overflow   <= 1'b0;
        r_trig_count <= '0;
      end else begin
        if (w_drop && r_state != IDLE) r_overflow <= 1'b1;
        if (r_state == WARMUP && ms.ms_sumout_vld)
          r_warm_cnt <= WIN_W'(r_warm_cnt + WIN_W'(1));
        if (w_hit) begin
          r_hold_cnt <= r_holdoff;
          if (r_trig_count != 16'hFFFF) r_trig_count <= r_trig_count + 16'd1;
        end else if (r_state == HOLDOFF && ms.ms_sumout_vld) begin
          r_hold_cnt <= HOLD_W'(r_hold_cnt - HOLD_W'(1));
        end
      end
    end
  end
endmodule

// File: tb/tb_edge_trig_ctrl.sv
// Directed bench for edge_trig_ctrl with a behavioural mov_sum stand-in.
module tb_edge_trig_ctrl;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        arm = 1'b0;
  logic [7:0]  cfg_window_width = 8'd1;
  logic        cfg_absolute = 1'b0;
  logic [31:0] cfg_threshold = '0;
  logic        cfg_falling = 1'b0;
  logic        cfg_oneshot = 1'b0;
  logic [15:0] cfg_holdoff = '0;
  logic [9:0]  adc_data = '0;
  logic        adc_valid = 1'b0;
  logic        trig_out, armed, overflow;
  logic [15:0] trig_count;

  int n_checks = 0;
  int n_pass = 0;
  int trig_hi = 0;

  logic        model_en = 1'b0;
  logic        model_clear = 1'b1;
  logic        man_read = 1'b0;
  int          model_width = 1;
  logic signed [9:0]  hist [8];
  logic signed [31:0] m_sum = '0;
  logic        m_vld = 1'b0;

  edge_trig_ctrl_if #(.ADC_W(10), .SUM_W(32), .WIN_W(8)) ms_bus ();

  edge_trig_ctrl dut (
    .ap_clk           (ap_clk),
    .ap_rst_n         (ap_rst_n),
    .arm              (arm),
    .cfg_window_width (cfg_window_width),
    .cfg_absolute     (cfg_absolute),
    .cfg_threshold    (cfg_threshold),
    .cfg_falling      (cfg_falling),
    .cfg_oneshot      (cfg_oneshot),
    .cfg_holdoff      (cfg_holdoff),
    .adc_data         (adc_data),
    .adc_valid        (adc_valid),
    .ms               (ms_bus.master),
    .trig_out         (trig_out),
    .armed            (armed),
    .overflow         (overflow),
    .trig_count       (trig_count)
  );

  always #5 ap_clk = ~ap_clk;

  assign ms_bus.ms_datain_read = model_en ? ms_bus.ms_datain_empty_n : man_read;
  assign ms_bus.ms_sumout      = m_sum;
  assign ms_bus.ms_sumout_vld  = m_vld;

  // Sum of the new sample and the previous model_width-1 samples.
  function automatic logic signed [31:0] next_sum(input logic signed [9:0] s_new);
    logic signed [31:0] acc;
    acc = 32'(s_new);
    for (int k = 0; k < model_width - 1; k++) acc += 32'(hist[k]);
    return acc;
  endfunction

  // mov_sum stand-in: pop a sample, emit its window sum one cycle later.
  always @(posedge ap_clk) begin
    if (model_clear) begin
      for (int k = 0; k < 8; k++) hist[k] <= '0;
      m_vld <= 1'b0;
    end else if (ms_bus.ms_datain_read && ms_bus.ms_datain_empty_n) begin
      m_sum <= next_sum(ms_bus.ms_datain_dout);
      for (int k = 7; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= ms_bus.ms_datain_dout;
      m_vld <= 1'b1;
    end else begin
      m_vld <= 1'b0;
    end
  end

  always @(posedge ap_clk) if (trig_out) trig_hi <= trig_hi + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic feed(input logic [9:0] v);
    @(negedge ap_clk);
    adc_data = v;
    adc_valid = 1'b1;
    @(negedge ap_clk);
    adc_valid = 1'b0;
    repeat (4) @(negedge ap_clk);
  endtask

  task automatic do_arm(input logic [7:0] w, input logic [31:0] thr, input logic fall,
                        input logic one, input logic [15:0] hold, input int mw);
    @(negedge ap_clk);
    arm = 1'b0;
    model_en = 1'b0;
    model_clear = 1'b1;
    ms_bus.ms_ap_idle = 1'b1;
    ms_bus.ms_ap_ready = 1'b1;
    cfg_window_width = w;
    cfg_threshold = thr;
    cfg_falling = fall;
    cfg_oneshot = one;
    cfg_holdoff = hold;
    cfg_absolute = 1'b1;
    model_width = mw;
    @(negedge ap_clk);
    arm = 1'b1;
    model_clear = 1'b0;
    repeat (4) @(negedge ap_clk);
    model_en = 1'b1;
    ms_bus.ms_ap_ready = 1'b0;
  endtask

  initial begin
    int t0;
    int cnt;
    int start_seen;
    logic [15:0] exp_cnt [9];
    logic [9:0]  ovf_in  [5];
    logic [9:0]  ovf_exp [4];
    exp_cnt = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd2, 16'd3, 16'd3, 16'd3};
    ovf_in  = '{10'd0, 10'd1023, 10'd100, 10'd200, 10'd300};
    ovf_exp = '{10'h200, 10'h1FF, 10'h264, 10'h2C8};
    ms_bus.ms_ap_idle = 1'b0;
    ms_bus.ms_ap_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge ap_clk);
    check("rst_flags", 32'({trig_out, armed, overflow, ms_bus.ms_ap_start,
                            ms_bus.ms_datain_empty_n, ms_bus.ms_absolute_value}), 32'd0);
    check("rst_width", 32'(ms_bus.ms_window_width), 32'd1);
    check("rst_count", 32'(trig_count), 32'd0);
    ap_rst_n = 1'b1;

    // One-shot rising trigger, width 3, threshold 100.
    do_arm(8'd3, 32'd100, 1'b0, 1'b1, 16'd0, 3);
    cfg_threshold = 32'd0;
    cfg_oneshot = 1'b0;
    check("os_width", 32'(ms_bus.ms_window_width), 32'd3);
    check("os_abs", 32'(ms_bus.ms_absolute_value), 32'd1);
    t0 = trig_hi;
    for (int i = 0; i < 3; i++) feed(10'd512);
    check("os_warm_cnt", 32'(trig_count), 32'd0);
    feed(10'd600);
    check("os_88_cnt", 32'(trig_count), 32'd0);
    check("os_88_armed", 32'(armed), 32'd1);
    feed(10'd600);
    check("os_176_cnt", 32'(trig_count), 32'd1);
    check("os_pulse", 32'(trig_hi - t0), 32'd1);
    check("os_disarm", 32'(armed), 32'd0);
    feed(10'd600);
    check("os_idle_push", 32'(ms_bus.ms_datain_empty_n), 32'd0);

    // Continuous mode with holdoff 2.
    do_arm(8'd3, 32'd100, 1'b0, 1'b0, 16'd2, 3);
    t0 = trig_hi;
    for (int i = 0; i < 3; i++) feed(10'd700);
    check("ho_warm_cnt", 32'(trig_count), 32'd0);
    for (int i = 0; i < 9; i++) begin
      feed(10'd700);
      check($sformatf("ho_cnt_%0d", i), 32'(trig_count), 32'(exp_cnt[i]));
    end
    check("ho_pulses", 32'(trig_hi - t0), 32'd3);
    check("ho_armed", 32'(armed), 32'd1);

    // Falling, threshold 50, width 0 coerced to 1.
    do_arm(8'd0, 32'd50, 1'b1, 1'b0, 16'd0, 1);
    check("fa_width", 32'(ms_bus.ms_window_width), 32'd1);
    feed(10'd400);
    check("fa_warm", 32'(trig_count), 32'd0);
    feed(10'd400);
    check("fa_hit", 32'(trig_count), 32'd1);
    feed(10'd480);
    check("fa_miss", 32'(trig_count), 32'd1);
    check("fa_armed", 32'(armed), 32'd1);

    // Most-negative threshold: -thr must be +2^31, so sum 0 fires.
    do_arm(8'd1, 32'h8000_0000, 1'b1, 1'b0, 16'd0, 1);
    feed(10'd512);
    feed(10'd512);
    check("mn_hit", 32'(trig_count), 32'd1);

    // Asynchronous reset while running.
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    check("ar_flags", 32'({trig_out, armed, overflow, ms_bus.ms_ap_start,
                           ms_bus.ms_datain_empty_n}), 32'd0);
    check("ar_count", 32'(trig_count), 32'd0);
    check("ar_width", 32'(ms_bus.ms_window_width), 32'd1);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Overflow with core stalled in WAIT_IDLE, plus start handshake.
    @(negedge ap_clk);
    arm = 1'b0;
    model_en = 1'b0;
    model_clear = 1'b1;
    ms_bus.ms_ap_idle = 1'b0;
    ms_bus.ms_ap_ready = 1'b0;
    @(negedge ap_clk);
    arm = 1'b1;
    start_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      if (ms_bus.ms_ap_start) start_seen++;
      adc_data = ovf_in[i];
      adc_valid = 1'b1;
    end
    @(negedge ap_clk);
    adc_valid = 1'b0;
    check("ov_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (ms_bus.ms_ap_start) start_seen++;
      check($sformatf("ov_data_%0d", i), 32'(ms_bus.ms_datain_dout), 32'(ovf_exp[i]));
      man_read = 1'b1;
      @(negedge ap_clk);
    end
    man_read = 1'b0;
    if (ms_bus.ms_ap_start) start_seen++;
    check("ov_empty", 32'(ms_bus.ms_datain_empty_n), 32'd0);
    check("hs_no_start", 32'(start_seen), 32'd0);
    ms_bus.ms_ap_idle = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ap_clk);
      if (ms_bus.ms_ap_start) cnt++;
      ms_bus.ms_ap_ready = (cnt >= 4);
    end
    ms_bus.ms_ap_ready = 1'b0;
    check("hs_start_len", 32'(cnt), 32'd4);
    arm = 1'b0;
    repeat (2) @(negedge ap_clk);
    check("ov_hold", 32'(overflow), 32'd1);
    arm = 1'b1;
    repeat (2) @(negedge ap_clk);
    check("ov_clear", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
